// File: rtl/pulse_stretcher_if.sv
// Signal bundle between a pulse source / status consumer and the pulse stretcher.
// The slave side is the stretcher; the master side drives pulses and observes status.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              i_in;
    logic              i_clr_ovf;
    logic              o_out;
    logic              o_busy;
    logic [PEND_W-1:0] o_pending;
    logic              o_ovf;

    modport master (
        output i_in, i_clr_ovf,
        input  o_out, o_busy, o_pending, o_ovf
    );

    modport slave (
        input  i_in, i_clr_ovf,
        output o_out, o_busy, o_pending, o_ovf
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Turns one-cycle pulses into WIDTH_CYC-cycle high windows separated by at least
// GAP_CYC low cycles; pulses arriving mid-window are queued in a saturating counter.
//
// state | meaning
// IDLE  | output low, nothing queued, waiting for a pulse
// HIGH  | output high, cnt counts down the remaining window cycles
// GAP   | output low, cnt counts down the remaining minimum gap cycles
module pulse_stretcher #(
    parameter int WIDTH_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    pulse_stretcher_if.slave  bus
);
    localparam int MAX_WG = (WIDTH_CYC > GAP_CYC) ? WIDTH_CYC : GAP_CYC;
    localparam int CNT_RANGE = (MAX_WG > 2) ? MAX_WG : 2;
    localparam int CNT_W = $clog2(CNT_RANGE);
    localparam logic [CNT_W-1:0] C_WIDTH = CNT_W'(WIDTH_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PEND_W-1:0] r_pending;
    logic              r_ovf;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PEND_W-1:0] w_pending_nxt;
    logic              w_ovf_set;
    logic              w_service;
    logic [PEND_W:0]   w_p_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            r_ovf     <= w_ovf_set | (r_ovf & ~bus.i_clr_ovf);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_ovf_set     = 1'b0;
        w_service     = 1'b0;
        // One bit wider so pending + in cannot wrap at saturation.
        w_p_eff       = {1'b0, r_pending} + {{PEND_W{1'b0}}, bus.i_in};

        case (r_state)
            IDLE: begin
                if (bus.i_in) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = C_WIDTH;
                end
            end
            HIGH: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (GAP_CYC > 0) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = C_GAP;
                end else begin
                    w_service = 1'b1;
                end
            end
            GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_service = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // A pulse landing on the service edge starts the next window directly.
        if (w_service) begin
            if (w_p_eff != '0) begin
                w_state_nxt   = HIGH;
                w_cnt_nxt     = C_WIDTH;
                w_pending_nxt = PEND_W'(w_p_eff - 1'b1);
            end else begin
                w_state_nxt = IDLE;
            end
        end else if ((r_state == HIGH || r_state == GAP) && bus.i_in) begin
            if (r_pending != PEND_MAX) begin
                w_pending_nxt = r_pending + 1'b1;
            end else begin
                w_ovf_set = 1'b1;
            end
        end
    end

    assign bus.o_out     = (r_state == HIGH);
    assign bus.o_busy    = (r_state != IDLE);
    assign bus.o_pending = r_pending;
    assign bus.o_ovf     = r_ovf;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench: three stretcher configurations (default, long window, no gap)
// driven from directed per-edge vector strings; a monitor checks each edge's result.
module tb_pulse_stretcher;
    logic clk;
    logic rst;

    pulse_stretcher_if #(.PEND_W(3)) if_a ();
    pulse_stretcher_if #(.PEND_W(3)) if_b ();
    pulse_stretcher_if #(.PEND_W(3)) if_c ();

    pulse_stretcher #(.WIDTH_CYC(4), .GAP_CYC(2), .PEND_W(3)) u_dut_a (
        .clk (clk), .rst (rst), .bus (if_a.slave)
    );
    pulse_stretcher #(.WIDTH_CYC(16), .GAP_CYC(2), .PEND_W(3)) u_dut_b (
        .clk (clk), .rst (rst), .bus (if_b.slave)
    );
    pulse_stretcher #(.WIDTH_CYC(4), .GAP_CYC(0), .PEND_W(3)) u_dut_c (
        .clk (clk), .rst (rst), .bus (if_c.slave)
    );

    typedef struct {
        int         id;
        int         edge_no;
        string      name;
        logic [5:0] exp;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec;
    int   n_miss;
    logic w_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] dut_vec(input int id);
        case (id)
            0:       return {if_a.o_out, if_a.o_busy, if_a.o_pending, if_a.o_ovf};
            1:       return {if_b.o_out, if_b.o_busy, if_b.o_pending, if_b.o_ovf};
            default: return {if_c.o_out, if_c.o_busy, if_c.o_pending, if_c.o_ovf};
        endcase
    endfunction

    task automatic check_now(input string name, input int id, input logic [5:0] exp);
        logic [5:0] act;
        act = dut_vec(id);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                     name, id, act[5], act[4], act[3:1], act[0], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    // Monitor: one expectation is pushed per checked edge; pop it just after that edge.
    initial begin
        exp_t e;
        logic [5:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                act = dut_vec(e.id);
                n_vec++;
                if (act !== e.exp) begin
                    n_miss++;
                    $display("FAIL %s edge%0d dut%0d: got out=%b busy=%b pend=%0d ovf=%b, want out=%b busy=%b pend=%0d ovf=%b",
                             e.name, e.edge_no, e.id, act[5], act[4], act[3:1], act[0],
                             e.exp[5], e.exp[4], e.exp[3:1], e.exp[0]);
                end
            end
        end
    end

    task automatic drive(input int id, input logic v_in, input logic v_clr);
        if_a.i_in = (id == 0) ? v_in : 1'b0;
        if_b.i_in = (id == 1) ? v_in : 1'b0;
        if_c.i_in = (id == 2) ? v_in : 1'b0;
        if_a.i_clr_ovf = (id == 0) ? v_clr : 1'b0;
        if_b.i_clr_ovf = (id == 1) ? v_clr : 1'b0;
        if_c.i_clr_ovf = (id == 2) ? v_clr : 1'b0;
    endtask

    // Each string position is one clock edge: inputs sampled there, outputs expected after it.
    task automatic run_seq(input string name, input int id, input string s_in, input string s_clr,
                           input string s_out, input string s_busy, input string s_pend,
                           input string s_ovf);
        exp_t e;
        for (int i = 0; i < s_in.len(); i++) begin
            @(negedge clk);
            drive(id, s_in[i] == "1", s_clr[i] == "1");
            e.id      = id;
            e.edge_no = i;
            e.name    = name;
            e.exp     = {s_out[i] == "1", s_busy[i] == "1", 3'(s_pend[i] - 8'h30), s_ovf[i] == "1"};
            q_exp.push_back(e);
        end
        @(negedge clk);
        drive(id, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        w_done = 1'b0;
        rst    = 1'b1;
        drive(0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_now("reset_state", 0, 6'b0);
        check_now("reset_state", 1, 6'b0);
        check_now("reset_state", 2, 6'b0);
        rst = 1'b0;

        run_seq("single_pulse", 0, "10000000", "00000000",
                "11110000", "11111100", "00000000", "00000000");
        run_seq("two_pulses", 0, "1010000000000", "0000000000000",
                "1111001111000", "1111111111110", "0011110000000", "0000000000000");
        run_seq("service_hit", 0, "1000001000000", "0000000000000",
                "1111001111000", "1111111111110", "0000000000000", "0000000000000");
        run_seq("service_hit_pend", 0, "1010001000000000000", "0000000000000000000",
                "1111001111001111000", "1111111111111111110", "0011111111110000000",
                "0000000000000000000");
        run_seq("saturate_ovf", 1, "111111111101", "000000000110",
                "111111111111", "111111111111", "012345677777", "000000001101");
        run_seq("gap0_merge", 2, "1100000000", "0000000000",
                "1111111100", "1111111100", "0111000000", "0000000000");

        // Build pending=2 mid-window, then reset between edges.
        run_seq("pre_reset", 0, "111", "000", "111", "111", "012", "000");
        @(posedge clk);
        #3;
        check_now("pre_reset_state", 0, {1'b1, 1'b1, 3'd2, 1'b0});
        rst = 1'b1;
        #1;
        check_now("async_reset_a", 0, 6'b0);
        check_now("async_reset_b", 1, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        run_seq("after_reset", 0, "10000000", "00000000",
                "11110000", "11111100", "00000000", "00000000");

        repeat (3) @(negedge clk);
        n_vec++;
        if (q_exp.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q_exp.size());
        end
        w_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Inverse of the team's Mealy edge detector: the detector turns a level into a one-cycle pulse; this block turns one-cycle pulses back into fixed-width levels.
- Each accepted input pulse produces an output high window of exactly WIDTH_CYC cycles, followed by a minimum low gap of GAP_CYC cycles.
- Pulses arriving while a window or gap is in progress are queued in a saturating pending counter.
- Sits downstream of edge detectors, driving LEDs, strobes, or slow-domain consumers.

Parameters:
- WIDTH_CYC, 4, output high time in cycles per pulse; must be >= 1.
- GAP_CYC, 2, minimum output low time between consecutive windows; 0 allowed.
- PEND_W, 3, width of the pending-pulse counter; saturates at 2^PEND_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  pulse input, sampled every rising edge; a multi-cycle high counts once per cycle.
- clr_ovf  input  1  synchronous clear of the ovf flag.
- out  output  1  stretched level; registered (Moore).
- busy  output  1  high whenever state != IDLE.
- pending  output  PEND_W  number of queued pulses not yet serviced.
- ovf  output  1  sticky flag: a pulse was dropped because pending was saturated.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is asynchronous and active-high.
  - On reset: state=IDLE, internal down-counter cnt=0, out=0, busy=0, pending=0, ovf=0.
  - Reset mid-operation drops out immediately, without waiting for a clock edge, and discards all queued pulses.
- States: IDLE, HIGH, GAP. Outputs decode from registers only: out = (state==HIGH), busy = (state!=IDLE). No combinational path from in to out.
- IDLE:
  - in=1 -> HIGH, cnt <= WIDTH_CYC-1. Latency: out rises on the edge that samples in.
  - in=0 -> stay in IDLE.
- HIGH:
  - cnt!=0 -> cnt decrements.
  - cnt==0 and GAP_CYC>0 -> GAP, cnt <= GAP_CYC-1.
  - cnt==0 and GAP_CYC==0 -> service point (see below).
  - Result: out stays high for exactly WIDTH_CYC cycles.
- GAP:
  - cnt!=0 -> cnt decrements.
  - cnt==0 -> service point.
- Service point:
  - p_eff = pending + in, computed PEND_W+1 bits wide.
  - p_eff>0 -> HIGH, cnt <= WIDTH_CYC-1, pending <= p_eff-1. This never overflows.
  - p_eff==0 -> IDLE.
  - With GAP_CYC==0, back-to-back windows merge into one continuous high level.
- Queuing, in HIGH or GAP on any non-service cycle:
  - in=1 and pending < max -> pending += 1.
  - in=1 and pending == max -> pending unchanged, ovf <= 1.
- ovf:
  - Set only by a dropped pulse.
  - Cleared by clr_ovf=1.
  - A set event and clr_ovf in the same cycle -> ovf=1 (set wins).
- Width rules:
  - cnt is $clog2(max(WIDTH_CYC,GAP_CYC,2)) bits wide.
  - All comparisons are unsigned.
  - pending never wraps.

Test Plan:
- Defaults, single pulse: in=1 sampled at edge 0 only.
  - out=1 after edges 0–3 and 0 after edge 4.
  - busy=1 through GAP; busy falls at edge 6.
  - pending=0 throughout.
- Defaults, pulse at edge 0 and edge 2:
  - pending=1 after edge 2.
  - out high for 4 cycles, low for 2, high again from edge 6 for 4 cycles.
  - pending returns to 0 at edge 6; IDLE at edge 12.
- Service-point coincidence (defaults):
  - Pulse at edge 0, and a second pulse landing exactly at the GAP cnt==0 edge (edge 6) -> second window starts at edge 6 with no extra gap, pending stays 0.
  - Repeat with pending=1 already queued -> pending remains 1 after edge 6.
- WIDTH_CYC=16, PEND_W=3, in held high for edges 0–8:
  - pending reaches 7 at edge 7.
  - ovf=1 after edge 8.
  - Assert clr_ovf together with another dropped pulse -> ovf stays 1.
  - clr_ovf alone on the next cycle -> ovf=0.
- GAP_CYC=0, pulses at edge 0 and edge 1 -> out continuously high for 8 cycles (edges 0–7), then IDLE.
- Reset mid-HIGH with pending=2 -> out, busy, pending, and ovf are 0 before the next clk edge; the first pulse after reset deassertion restarts a normal 4-cycle window.
